// File: rtl/rpn_exec.sv
// Stack-machine execution unit driving push/pop/data_in of an attached DEPTH-entry stack.
// Optional shifts (opcodes 8 SHL, 9 SHR) are enabled by defining RPN_EXEC_SHIFT_EN.
module rpn_exec #(
  parameter int unsigned DEPTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [3:0]  opcode,
  input  logic [31:0] imm,
  input  logic [31:0] stack_top,
  input  logic [31:0] stack_top_minus_one,
  output logic        push,
  output logic        pop,
  output logic [31:0] data_out,
  output logic [31:0] result,
  output logic        result_valid,
  output logic        error,
  output logic [5:0]  depth
);

  localparam logic [5:0] Full = 6'(DEPTH);

  typedef enum logic [1:0] {StIdle, StPop1, StPop2, StPush} state_e;

  state_e      state_q, state_d;
  logic [5:0]  depth_q, depth_d;
  logic [31:0] val_q, val_d;
  logic [31:0] result_q, result_d;
  logic        error_q, error_d;
  logic [31:0] alu_res;

  // A = word below top, B = top.
  always_comb begin
    alu_res = '0;
    case (opcode)
      4'd2: alu_res = stack_top_minus_one + stack_top;
      4'd3: alu_res = stack_top_minus_one - stack_top;
      4'd4: alu_res = stack_top_minus_one & stack_top;
      4'd5: alu_res = stack_top_minus_one | stack_top;
      4'd6: alu_res = stack_top_minus_one ^ stack_top;
`ifdef RPN_EXEC_SHIFT_EN
      4'd8: alu_res = stack_top_minus_one << stack_top[4:0];
      4'd9: alu_res = stack_top_minus_one >> stack_top[4:0];
`endif
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    depth_d  = depth_q;
    val_d    = val_q;
    result_d = result_q;
    error_d  = 1'b0;
    case (state_q)
      StIdle: begin
        if (instr_valid) begin
          case (opcode)
            4'd0: ;
            4'd1: begin
              if (depth_q == Full) begin
                error_d = 1'b1;
              end else begin
                val_d   = imm;
                state_d = StPush;
              end
            end
            4'd2, 4'd3, 4'd4, 4'd5, 4'd6
`ifdef RPN_EXEC_SHIFT_EN
            , 4'd8, 4'd9
`endif
            : begin
              if (depth_q < 6'd2) begin
                error_d = 1'b1;
              end else begin
                val_d   = alu_res;
                state_d = StPop1;
              end
            end
            4'd7: begin
              if (depth_q == 6'd0 || depth_q == Full) begin
                error_d = 1'b1;
              end else begin
                val_d   = stack_top;
                state_d = StPush;
              end
            end
            default: error_d = 1'b1;
          endcase
        end
      end
      StPop1: begin
        state_d = StPop2;
        depth_d = depth_q - 6'd1;
      end
      StPop2: begin
        state_d = StPush;
        depth_d = depth_q - 6'd1;
      end
      StPush: begin
        state_d  = StIdle;
        depth_d  = depth_q + 6'd1;
        result_d = val_q;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      depth_q  <= '0;
      val_q    <= '0;
      result_q <= '0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      depth_q  <= depth_d;
      val_q    <= val_d;
      result_q <= result_d;
      error_q  <= error_d;
    end
  end

  assign instr_ready  = (state_q == StIdle);
  assign push         = (state_q == StPush);
  assign pop          = (state_q == StPop1) || (state_q == StPop2);
  assign data_out     = push ? val_q : '0;
  // New result is visible during the push cycle itself, then held.
  assign result       = push ? val_q : result_q;
  assign result_valid = push;
  assign error        = error_q;
  assign depth        = depth_q;

endmodule

// File: doc/rpn_exec.md
# rpn_exec

Stack-machine execution unit sitting directly upstream of the 32-entry `stack` block. Accepts one instruction at a time over a valid/ready handshake and sequences the stack's `push`/`pop`/`data_in` controls. Reads the stack's `stack_top`/`stack_top_minus_one` outputs for operands and writes results back as a new top-of-stack. Tracks its own occupancy count and rejects underflow, overflow and illegal opcodes with a one-cycle error pulse.

## Interface
- `DEPTH`, 32: stack capacity in entries; must match the attached stack.
- `clk` input 1: clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `instr_valid` input 1: instruction present on `opcode`/`imm`.
- `instr_ready` output 1: unit can accept an instruction this cycle.
- `opcode` input 4: operation select (see Operation).
- `imm` input 32: immediate for PUSHI.
- `stack_top` input 32: current top-of-stack word from the stack.
- `stack_top_minus_one` input 32: word below top from the stack.
- `push` output 1: to stack `push`.
- `pop` output 1: to stack `pop`.
- `data_out` output 32: to stack `data_in`.
- `result` output 32: last value written by PUSHI/ALU/DUP.
- `result_valid` output 1: one-cycle pulse when `result` is written to the stack.
- `error` output 1: one-cycle pulse on a rejected instruction.
- `depth` output 6: current occupancy, 0..DEPTH.

## Operation
- Opcodes: 0 NOP, 1 PUSHI, 2 ADD, 3 SUB, 4 AND, 5 OR, 6 XOR, 7 DUP; 8 SHL and 9 SHR only with the macro; all others illegal.
- Operand naming: A = `stack_top_minus_one`, B = `stack_top`. SUB = A − B. SHL = A << B[4:0]. SHR = A >> B[4:0] (logical).
- All arithmetic is 32-bit modulo 2^32. No carry, overflow or flag outputs.
- FSM states: IDLE, POP1, POP2, PUSH. `instr_ready` = (state == IDLE).
- Accept: `instr_valid && instr_ready`. At accept, evaluate the conditions below in order:
  - Illegal opcode -> `error` pulse next cycle, stay IDLE.
  - NOP -> no effect, stay IDLE.
  - PUSHI: `depth==DEPTH` -> error; else latch `imm` -> PUSH.
  - Binary op (2–6, 8, 9): `depth<2` -> error; else latch A and B, compute result -> POP1.
  - DUP: `depth==0` or `depth==DEPTH` -> error; else latch B -> PUSH.
- Transitions: POP1 -> POP2 -> PUSH -> IDLE, unconditional.
- Outputs are decoded from registered state:
  - `pop` = 1 in POP1 and POP2.
  - `push` = 1 in PUSH, with `data_out` = latched value.
  - `push` and `pop` are never high together.
- `depth`: +1 on each `push` cycle, −1 on each `pop` cycle. Never leaves 0..DEPTH.
- `result` updates in the PUSH cycle and holds until the next PUSH. `result_valid` = 1 in PUSH.
- `error` does not alter `depth` or the stack. The next instruction may be accepted the cycle after the error.

## Timing
- Reset (synchronous): state IDLE, `depth`=0, `push`=`pop`=0, `data_out`=0, `result`=0, `result_valid`=0, `error`=0, `instr_ready`=1 in the cycle after reset deasserts.
- Reset asserted mid-sequence aborts it with no further push/pop. The stack shares `rst`, so both return to empty together.
- Instruction accepted in cycle N:
  - PUSHI/DUP: push in N+1, ready again N+2.
  - Binary op: pop N+1, pop N+2, push N+3, ready N+4.
  - Error/NOP: `error` (if any) in N+1, ready in N+1.
- Operands are sampled only in the accept cycle. Stack outputs during POP1/POP2 are ignored.
- `instr_valid` while not ready is ignored, not queued; the producer holds it.

## Configuration
- `RPN_EXEC_SHIFT_EN`:
  - Defined: opcodes 8 (SHL) and 9 (SHR) are legal binary ops.
  - Undefined: 8 and 9 are illegal and produce `error` with no stack activity. The shifter is not synthesized.

## Test plan
- Reset, PUSHI 5, PUSHI 3, SUB -> pops at N+1/N+2, push 2 at N+3, `result`=2, `depth`=1, stack_top=2.
- PUSHI 0xFFFFFFFF, PUSHI 1, ADD -> `result`=0 (wrap), `depth`=1.
- From empty: ADD -> `error` pulse, no push/pop, `depth`=0. PUSHI 7, DUP, XOR -> `result`=0.
- 32× PUSHI then PUSHI and DUP -> both `error`, `depth` stays 32, top unchanged.
- Opcode 8 with A=1, B=4: macro on -> `result`=16; macro off -> `error`. Opcode 15 -> `error`.
- Assert `rst` in POP2 of an ADD -> next cycle `push`=`pop`=0, `depth`=0, `instr_ready`=1.
